mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive data grants allowed while fetch waits before fetch is forced.
REQ-002 Parameter AW, default 32: address/data width.
REQ-003 CLK  input  1  single clock; all state updates on posedge.
REQ-004 Reset_L  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch read request; held until if_done.
REQ-006 if_addr  input  AW  fetch word address; stable while if_req high.
REQ-007 if_rdata  output  AW  fetched instruction, valid with if_done.
REQ-008 if_done  output  1  one-cycle completion pulse for fetch.
REQ-009 d_req  input  1  data-stage request; held until d_done.
REQ-010 d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-011 d_addr  input  AW  data address; stable while d_req high.
REQ-012 d_wdata  input  AW  store data.
REQ-013 d_rdata  output  AW  load data, valid with d_done.
REQ-014 d_done  output  1  one-cycle completion pulse for data access.
REQ-015 m_req, m_we  output  1 each  shared single-port memory request/write-enable.
REQ-016 m_addr, m_wdata  output  AW each  shared memory address/write data.
REQ-017 m_rdata  input  AW  memory read data, valid when m_ready high.
REQ-018 m_ready  input  1  memory completion; may arrive 1..N cycles after m_req.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, DONE; reset state IDLE.
REQ-020 IDLE: if no request, stay; else latch grant owner, drive m_req/m_we/m_addr/m_wdata registered from next cycle, go ACCESS.
REQ-021 Priority: d_req wins over if_req, except when both requested and starve count == STARVE_MAX, then fetch wins.
REQ-022 Starve count: +1 per data grant while if_req high; cleared on fetch grant or when if_req low in IDLE; saturates at STARVE_MAX.
REQ-023 ACCESS: hold m_* outputs stable; on m_ready=1 register m_rdata into owner's rdata (loads/fetches only), drop m_req, go DONE.
REQ-024 DONE: assert owner's done for exactly one cycle; go IDLE; requests ignored in DONE.
REQ-025 Minimum latency: req sampled in IDLE at cycle n, m_req high n+1, m_ready at n+1 gives done at n+2; next grant sampled n+3.
REQ-026 Fetch grants SHALL force m_we=0; for stores, d_rdata SHALL retain its previous value.
REQ-027 if_rdata/d_rdata SHALL hold value until next completion of same owner.
REQ-028 m_ready while not in ACCESS SHALL be ignored.
REQ-029 Requester deasserting req during ACCESS SHALL NOT abort access; done still pulses.
REQ-030 Addresses passed unmodified; no alignment checks.

Reset
REQ-031 Reset_L low SHALL immediately (asynchronously) force IDLE, starve count 0, m_req=m_we=0, m_addr=m_wdata=0, if_done=d_done=0, if_rdata=d_rdata=0.
REQ-032 Reset mid-ACCESS SHALL abandon the access; no done pulse after release.
REQ-033 First grant possible on first posedge after Reset_L deasserts.

Structure
REQ-034 Shared package mips_pkg SHALL hold state encoding (IDLE=0, ACCESS=1, DONE=2), owner encoding (OWN_IF=0, OWN_D=1), word width 32, STARVE_MAX default.
REQ-035 Starvation counter SHALL be a sub-module arb_starve_cnt (inc, clr, sat output); FSM and muxing stay in top.

Verification
REQ-036 Single fetch: if_req, if_addr=0x60, m_ready 1 cycle after m_req with m_rdata=0x8C010004 -> m_addr=0x60, m_we=0, if_done one pulse, if_rdata=0x8C010004.
REQ-037 Simultaneous: if_req and d_req (load 0x100) same cycle -> data granted first, d_done then if_done; m_addr 0x100 then fetch address.
REQ-038 Starvation: if_req held, d_req held, STARVE_MAX=3 -> grant order D,D,D,IF,D...
REQ-039 Store: d_we=1, d_addr=0x200, d_wdata=0xFEEDBEEF, m_ready after 4 cycles -> m_we=1, m_wdata=0xFEEDBEEF stable 4 cycles, d_done one pulse, d_rdata unchanged.
REQ-040 Reset mid-ACCESS: Reset_L low 1 cycle after m_req, m_ready returned later -> outputs 0 immediately, no done pulse, IDLE after release.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mips_pkg                                                     |
// | Description : Shared types and constants for the memory port arbiter:     |
// |               FSM state encoding, grant owner encoding, word width and    |
// |               the default fetch-starvation limit.                         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_starve_cnt                                               |
// | Description : Saturating count of data grants given while a fetch request |
// |               is waiting. Clear has priority over increment.              |
// | Ports       : CLK     - clock                                             |
// |               Reset_L - asynchronous active-low reset                     |
// |               inc_i   - one data grant issued while fetch waits           |
// |               clr_i   - fetch granted or no fetch pending                 |
// |               sat_o   - count has reached STARVE_MAX                      |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module arb_starve_cnt
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic CLK,
  input  logic Reset_L,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  // At least one bit so a limit of 0 still elaborates (fetch then always wins).
  localparam int            CW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == C_MAX);

endmodule : arb_starve_cnt
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one single-port memory between an instruction fetch |
// |               requester and a data (load/store) requester. Data has      |
// |               priority unless fetch has been passed over STARVE_MAX      |
// |               consecutive times. One access in flight at a time:         |
// |               IDLE (arbitrate) -> ACCESS (wait m_ready) -> DONE (pulse). |
// | Ports       : CLK, Reset_L             - clock, async active-low reset   |
// |               if_req/if_addr           - fetch request and word address  |
// |               if_rdata/if_done         - fetched word, completion pulse  |
// |               d_req/d_we/d_addr/d_wdata - data request                   |
// |               d_rdata/d_done           - load data, completion pulse     |
// |               m_req/m_we/m_addr/m_wdata - registered memory request      |
// |               m_rdata/m_ready          - memory read data, completion    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = WORD_W
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [AW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic [AW-1:0] d_rdata,
  output logic          d_done,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [AW-1:0] m_wdata,
  input  logic [AW-1:0] m_rdata,
  input  logic          m_ready
);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [AW-1:0] m_wdata_q, m_wdata_d;
  logic [AW-1:0] if_rdata_q, if_rdata_d;
  logic [AW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;

  logic          starve_sat;
  logic          starve_inc;
  logic          starve_clr;
  logic          fetch_win;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .inc_i   (starve_inc),
    .clr_i   (starve_clr),
    .sat_o   (starve_sat)
  );

  // Fetch only wins a contested grant once it has been passed over enough.
  assign fetch_win = if_req && (!d_req || starve_sat);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    case (state_q)
      IDLE: begin
        starve_clr = !if_req;
        if (if_req || d_req) begin
          state_d = ACCESS;
          m_req_d = 1'b1;
          if (fetch_win) begin
            owner_d    = OWN_IF;
            m_we_d     = 1'b0;
            m_addr_d   = if_addr;
            m_wdata_d  = '0;
            starve_clr = 1'b1;
          end else begin
            owner_d    = OWN_D;
            m_we_d     = d_we;
            m_addr_d   = d_addr;
            m_wdata_d  = d_wdata;
            starve_inc = if_req;
          end
        end
      end

      ACCESS: begin
        if (m_ready) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = m_rdata;
            if_done_d  = 1'b1;
          end else begin
            // Stores leave the load-data register untouched.
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
            d_done_d = 1'b1;
          end
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;

endmodule : mem_port_arbiter
`default_nettype wire
